// File: rtl/reg_stage_fifo_pkg.sv
// Shared constants and types for the register-stage FIFO.
// Provides default width/depth, count width and head-select codes.
package reg_stage_fifo_pkg;

    localparam int STAGE_WIDTH = 3;
    localparam int STAGE_DEPTH = 4;

    // Occupancy needs one extra bit so that "full" (== DEPTH) is representable.
    localparam int STAGE_CNT_W = $clog2(STAGE_DEPTH) + 1;

    // Source of the output register value after the next edge.
    typedef enum logic [1:0] {
        HEAD_HOLD = 2'd0,
        HEAD_IN   = 2'd1,
        HEAD_MEM  = 2'd2
    } head_sel_e;

endpackage

// File: rtl/reg_stage_mem.sv
// DEPTH x WIDTH register array, one write port, one async read port.
// Ports: clk, we, waddr, wdata (write); raddr -> rdata (combinational read).
module reg_stage_mem #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Entries carry no reset: they are only read after being written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/reg_stage_fifo.sv
// Register-stage FIFO with registered head output and 1-cycle latency.
// Ports: clk, rst (async low), flush; in_valid/in_data/in_ready upstream;
// out_valid/out_data/out_ready downstream; count = occupancy.
module reg_stage_fifo
    import reg_stage_fifo_pkg::*;
#(
    parameter int WIDTH = STAGE_WIDTH,
    parameter int DEPTH = STAGE_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_next;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] mem_rdata;
    logic             push;
    logic             pop;
    head_sel_e        head_sel;

    assign in_ready  = (cnt_q != CNT_FULL) && rst;
    assign out_valid = (cnt_q != '0);
    assign out_data  = dout_q;
    assign count     = cnt_q;

    assign push    = in_valid && in_ready;
    assign pop     = out_valid && out_ready;
    assign rd_next = rd_ptr + PTR_ONE;

    reg_stage_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push && !flush),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (rd_next),
        .rdata (mem_rdata)
    );

    // The output register always mirrors the entry at rd_ptr. After a pop
    // with more than one entry the successor is already in storage; when
    // the FIFO is (or becomes) empty the incoming word goes straight in.
    always_comb begin
        head_sel = HEAD_HOLD;
        unique case (1'b1)
            (pop && (cnt_q > CNT_ONE)): begin
                head_sel = HEAD_MEM;
            end
            (push && ((cnt_q == '0) || (pop && (cnt_q == CNT_ONE)))): begin
                head_sel = HEAD_IN;
            end
            default: begin
                head_sel = HEAD_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_next;
            end
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
            unique case (head_sel)
                HEAD_IN:  dout_q <= in_data;
                HEAD_MEM: dout_q <= mem_rdata;
                default:  dout_q <= dout_q;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_stage_fifo.sv
// Directed self-checking bench for reg_stage_fifo.
// Covers reset, single word, full, streaming, backpressure, flush, reset.
module tb_reg_stage_fifo;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic [2:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [2:0] out_data;
    logic       out_ready;
    logic [2:0] count;

    int checks;
    int failures;

    reg_stage_fifo #(
        .WIDTH (3),
        .DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [2:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        #1;
        chk("rst_count", count, 0);
        chk("rst_ovalid", out_valid, 0);
        chk("rst_odata", out_data, 0);
        chk("rst_iready", in_ready, 0);

        #11;
        rst = 1'b1;
        #1;
        chk("rel_iready", in_ready, 1);

        // single word
        push1(3'h5);
        chk("single_ovalid", out_valid, 1);
        chk("single_odata", out_data, 5);
        chk("single_count", count, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("single_pop_count", count, 0);
        chk("single_pop_ovalid", out_valid, 0);

        // fill to full, overflow ignored, ordered drain
        for (int i = 1; i <= 4; i++) begin
            push1(3'(i));
        end
        chk("full_count", count, 4);
        chk("full_iready", in_ready, 0);
        push1(3'h7);
        chk("ovf_count", count, 4);
        chk("ovf_head", out_data, 1);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_data", out_data, i);
            step();
        end
        out_ready = 1'b0;
        chk("drain_count", count, 0);
        chk("drain_ovalid", out_valid, 0);

        // underflow ignored
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("udf_count", count, 0);

        // steady streaming 0..7
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_data = 3'(k);
            step();
            chk("stream_count", count, 1);
            chk("stream_data", out_data, k);
            chk("stream_ovalid", out_valid, 1);
        end
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        chk("stream_end_count", count, 0);

        // backpressure holds head
        push1(3'h3);
        push1(3'h4);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("bp_data", out_data, 3);
            chk("bp_count", count, 2);
        end
        out_ready = 1'b1;
        step();
        chk("bp_next", out_data, 4);
        step();
        out_ready = 1'b0;
        chk("bp_empty", count, 0);

        // flush beats a simultaneous push
        push1(3'h1);
        push1(3'h2);
        push1(3'h3);
        chk("pre_flush_count", count, 3);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 3'h6;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_count", count, 0);
        chk("flush_ovalid", out_valid, 0);
        push1(3'h2);
        chk("post_flush_data", out_data, 2);
        chk("post_flush_count", count, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("post_flush_empty", count, 0);

        // asynchronous reset mid-operation
        push1(3'h5);
        push1(3'h6);
        chk("pre_rst_count", count, 2);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_ovalid", out_valid, 0);
        chk("arst_odata", out_data, 0);
        chk("arst_iready", in_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rerel_iready", in_ready, 1);
        out_ready = 1'b1;
        step();
        chk("rerel_ovalid", out_valid, 0);
        chk("rerel_count", count, 0);
        out_ready = 1'b0;
        push1(3'h7);
        chk("rerel_data", out_data, 7);
        chk("rerel_count1", count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
